ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED "set LEDs" or 0xFF "reset". It is the counterpart of the existing ps2_keyboard receiver. It drives the open-drain PS/2 clock and data lines through low-drive enables. The device generates the clock; this block follows it bit by bit and checks the device's acknowledge.

---
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional watchdog: PS2_TX_TIMEOUT_EN)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drv_low,
    output logic       ps2_data_drv_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [INH_W-1:0] r_inh_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_shift;
    logic             r_data_low;
    logic             r_ok;
    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_s3;
    logic             r_data_s1;
    logic             r_data_s2;
    logic             w_fall;
    logic             w_inh_last;
    logic             w_timeout;
    logic             w_clk_drv;
    logic             w_data_drv;
    logic             w_done;
    logic             w_err;

    // Two-flop synchronisers on both pins plus a third clock flop for edge detect;
    // idle value is 1 so reset never fakes a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
            r_data_s1 <= ps2_data_in;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_fall     = r_clk_s3 & ~r_clk_s2;
    assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_wdog;

    // Watchdog: zero while idle (so it is clear at accept), counts every busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + TO_W'(1);
        end
    end

    assign w_timeout = (r_state != S_IDLE) && (r_wdog == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build; the transfer waits on the device indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and line/pulse decode; a timeout overrides everything, including a fall.
    always_comb begin
        w_next     = r_state;
        w_clk_drv  = 1'b0;
        w_data_drv = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        if (w_timeout) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        w_next = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    w_clk_drv = 1'b1;
                    if (w_inh_last) begin
                        w_data_drv = 1'b1;
                        w_next     = S_START;
                    end
                end
                S_START: begin
                    w_data_drv = r_data_low;
                    if (w_fall) begin
                        w_next = S_SEND;
                    end
                end
                S_SEND: begin
                    w_data_drv = r_data_low;
                    if (w_fall && (r_bit_cnt == 4'd9)) begin
                        w_next = S_ACK;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        w_next = S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_clk_s2 && r_data_s2) begin
                        w_done = r_ok;
                        w_err  = ~r_ok;
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Frame datapath: capture on accept, inhibit timing, one bit per device clock fall, ACK sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data_low <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_shift    <= {~^tx_data, tx_data};
                        r_inh_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_data_low <= 1'b0;
                        r_ok       <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + INH_W'(1);
                    if (w_inh_last) begin
                        r_data_low <= 1'b1;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START, S_SEND: begin
                    if (w_fall) begin
                        if (r_bit_cnt == 4'd9) begin
                            r_data_low <= 1'b0;
                        end else begin
                            r_data_low <= ~r_shift[r_bit_cnt];
                        end
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        r_ok <= ~r_data_s2;
                    end
                end
                default: begin
                end
            endcase
            if (w_timeout) begin
                r_data_low <= 1'b0;
            end
        end
    end

    assign tx_ready         = (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign ps2_clk_drv_low  = w_clk_drv;
    assign ps2_data_drv_low = w_data_drv;
    assign tx_done          = w_done;
    assign tx_err           = w_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_drv_low;
    logic       ps2_data_drv_low;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       bus_clk;
    logic       bus_data;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign bus_clk  = ~ps2_clk_drv_low & dev_clk;
    assign bus_data = ~ps2_data_drv_low & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .ps2_clk_in      (bus_clk),
        .ps2_data_in     (bus_data),
        .ps2_clk_drv_low (ps2_clk_drv_low),
        .ps2_data_drv_low(ps2_data_drv_low),
        .busy            (busy),
        .tx_done         (tx_done),
        .tx_err          (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "stuck");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one frame from the host's point of view; caller has already raised tx_valid.
    task automatic do_frame(input logic [7:0] ebyte, input bit ack, input bit keep_valid,
                            input logic [7:0] next_data, input int abort_at);
        int n;
        int lo;
        int pd;
        int pe;
        int d0;
        int e0;
        logic ready_in_pulse;
        logic [9:0] bits;
        bits = {1'b1, ~^ebyte, ebyte};
        d0 = done_cnt;
        e0 = err_cnt;
        n = 0;
        while (ps2_clk_drv_low !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("inhibit_seen_%02h", ebyte), 32'(n < 100), 1);
        if (!keep_valid) tx_valid = 1'b0;
        tx_data = next_data;
        lo = 0;
        while (ps2_clk_drv_low === 1'b1 && lo < 1000) begin
            lo++;
            @(negedge clk);
        end
        check($sformatf("inhibit_len_%02h", ebyte), lo, INH);
        check($sformatf("start_bit_%02h", ebyte), ps2_data_drv_low, 1);
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (i <= 10) check($sformatf("bit%0d_%02h", i, ebyte), bus_data, bits[i-1]);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_clk_rel", ps2_clk_drv_low, 0);
                check("abort_data_rel", ps2_data_drv_low, 0);
                check("abort_busy", busy, 0);
                dev_clk = 1'b1;
                repeat (20) @(negedge clk);
                rst = 1'b0;
                repeat (5) @(negedge clk);
                #1;
                check("abort_no_done", done_cnt - d0, 0);
                check("abort_no_err", err_cnt - e0, 0);
                return;
            end
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
        end
        pd = 0;
        pe = 0;
        n = 0;
        ready_in_pulse = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (tx_done || tx_err) ready_in_pulse = tx_ready;
            if (tx_done) pd++;
            if (tx_err) pe++;
            if ((pd + pe) > 0 && tx_ready) break;
        end
        check($sformatf("end_seen_%02h", ebyte), 32'(n < 100), 1);
        check($sformatf("done_pulses_%02h", ebyte), pd, ack ? 1 : 0);
        check($sformatf("err_pulses_%02h", ebyte), pe, ack ? 0 : 1);
        check($sformatf("ready_in_pulse_%02h", ebyte), ready_in_pulse, 0);
        check($sformatf("ready_after_%02h", ebyte), tx_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_drv", ps2_clk_drv_low, 0);
        check("rst_data_drv", ps2_data_drv_low, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // A device clock fall while idle must not start anything.
        dev_clk = 1'b0;
        repeat (10) @(negedge clk);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_fall_ignored", busy, 0);

        tx_data = 8'hED; tx_valid = 1'b1;
        do_frame(8'hED, 1'b1, 1'b0, 8'hED, 0);
        repeat (5) @(negedge clk);

        tx_data = 8'h00; tx_valid = 1'b1;
        do_frame(8'h00, 1'b1, 1'b0, 8'h00, 0);
        repeat (5) @(negedge clk);

        tx_data = 8'hFF; tx_valid = 1'b1;
        do_frame(8'hFF, 1'b1, 1'b0, 8'hFF, 0);
        repeat (5) @(negedge clk);

        tx_data = 8'hA3; tx_valid = 1'b1;
        do_frame(8'hA3, 1'b0, 1'b0, 8'hA3, 0);
        repeat (5) @(negedge clk);

        tx_data = 8'h12; tx_valid = 1'b1;
        do_frame(8'h12, 1'b1, 1'b1, 8'h34, 0);
        do_frame(8'h34, 1'b1, 1'b0, 8'h34, 0);
        repeat (5) @(negedge clk);

        tx_data = 8'h55; tx_valid = 1'b1;
        do_frame(8'h55, 1'b1, 1'b0, 8'h55, 4);
        repeat (5) @(negedge clk);

        tx_data = 8'hA5; tx_valid = 1'b1;
        do_frame(8'hA5, 1'b1, 1'b0, 8'hA5, 0);
        repeat (5) @(negedge clk);

`ifdef PS2_TX_TIMEOUT_EN
        begin
            int n;
            n = 0;
            tx_data = 8'h77; tx_valid = 1'b1;
            while (n < 3000) begin
                @(negedge clk);
                n++;
                if (n == 1) tx_valid = 1'b0;
                if (tx_err) break;
            end
            check("timeout_latency", n, TMO);
            check("timeout_clk_rel", ps2_clk_drv_low, 0);
            check("timeout_data_rel", ps2_data_drv_low, 0);
            check("timeout_no_done", tx_done, 0);
            @(negedge clk);
            check("timeout_ready", tx_ready, 1);
        end
`endif

        #1;
        check("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
